binary_quiz_core: RTL

Game engine for the binary-counting game. Draws a pseudo-random target value and presents it for display. The player sets the answer switches and presses submit; the block judges the answer, keeps score, enforces a per-round timeout and runs a fixed number of rounds.

---
 rtl/binary_quiz_pkg.sv | 26 ++
 rtl/binary_quiz_core_lfsr16.sv | 33 +++
 rtl/binary_quiz_core.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/binary_quiz_pkg.sv
// Shared types and constants for the binary-counting quiz engine.
// Latency: n/a (package only).
// Backpressure: n/a.
package binary_quiz_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GEN,
        WAIT,
        RESULT,
        DONE
    } state_t;

    localparam int          LFSR_W            = 16;
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // Right-shifting Galois step for x^16+x^14+x^13+x^11+1.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        logic [LFSR_W-1:0] nxt;
        nxt = cur >> 1;
        if (cur[0]) nxt = nxt ^ LFSR_TAPS;
        return nxt;
    endfunction

endpackage

// File: rtl/binary_quiz_core_lfsr16.sv
// Free-running 16-bit Galois LFSR used as the target source.
// Latency: new value every enabled cycle.
// Backpressure: none; ena low holds the register.
module lfsr16
    import binary_quiz_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    output logic [15:0] q
);

    // An all-zero seed would lock the sequence at zero forever.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? LFSR_DEFAULT_SEED : SEED;

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = q_q;
        if (ena) q_d = lfsr_next(q_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= SEED_EFF;
        else        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/binary_quiz_core.sv
// Quiz engine: draws a target, judges submitted answers, times out rounds, keeps score.
// Latency: verdict flags one cycle after the submit edge; next target RESULT_CYCLES+1 later.
// Backpressure: none; inputs are sampled levels, ena low freezes every register.
module binary_quiz_core
    import binary_quiz_pkg::*;
#(
    parameter int          WIDTH          = 8,
    parameter int          ROUNDS         = 10,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter int          RESULT_CYCLES  = 500,
    parameter logic [15:0] SEED           = 16'hACE1,
    localparam int         SW             = $clog2(ROUNDS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             submit,
    input  logic [WIDTH-1:0] answer,
    output logic [WIDTH-1:0] target,
    output logic [SW-1:0]    score,
    output logic [SW-1:0]    round,
    output logic             active,
    output logic             correct,
    output logic             wrong,
    output logic             timeout,
    output logic             done
);

    // One down-counter serves both the answer window and the verdict hold.
    localparam int             CNT_MAX   = (TIMEOUT_CYCLES > RESULT_CYCLES) ? TIMEOUT_CYCLES : RESULT_CYCLES;
    localparam int             CW        = $clog2(CNT_MAX);
    localparam logic [CW-1:0]  TMO_INIT  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]  RES_INIT  = CW'(RESULT_CYCLES - 1);
    localparam logic [SW-1:0]  ROUNDS_SW = SW'(ROUNDS);
    localparam logic [15:0]    LOW_MASK  = 16'((32'h1 << WIDTH) - 32'h1);

    logic [15:0]      lfsr_val;
    state_t           state_q,   state_d;
    logic [WIDTH-1:0] target_q,  target_d;
    logic [SW-1:0]    score_q,   score_d;
    logic [SW-1:0]    round_q,   round_d;
    logic [CW-1:0]    timer_q,   timer_d;
    logic             correct_q, correct_d;
    logic             wrong_q,   wrong_d;
    logic             timeout_q, timeout_d;
    logic             start_q,   start_d;
    logic             submit_q,  submit_d;
    logic             start_re;
    logic             submit_re;
    logic             draw_zero;
    logic [SW-1:0]    round_inc;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .q     (lfsr_val)
    );

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        score_d   = score_q;
        round_d   = round_q;
        timer_d   = timer_q;
        correct_d = correct_q;
        wrong_d   = wrong_q;
        timeout_d = timeout_q;
        start_d   = start_q;
        submit_d  = submit_q;
        start_re  = start & ~start_q;
        submit_re = submit & ~submit_q;
        draw_zero = ((lfsr_val & LOW_MASK) == 16'h0);
        round_inc = round_q + SW'(1);

        if (ena) begin
            start_d  = start;
            submit_d = submit;
            case (state_q)
                IDLE, DONE: begin
                    if (start_re) begin
                        state_d = GEN;
                        score_d = '0;
                        round_d = '0;
                    end
                end
                GEN: begin
                    // Zero is never a playable target.
                    target_d = draw_zero ? WIDTH'(1) : lfsr_val[WIDTH-1:0];
                    timer_d  = TMO_INIT;
                    state_d  = WAIT;
                end
                WAIT: begin
                    if (submit_re) begin
                        state_d = RESULT;
                        timer_d = RES_INIT;
                        if (answer == target_q) begin
                            correct_d = 1'b1;
                            if (score_q != ROUNDS_SW) score_d = score_q + SW'(1);
                        end else begin
                            wrong_d = 1'b1;
                        end
                    end else if (timer_q == '0) begin
                        state_d   = RESULT;
                        timer_d   = RES_INIT;
                        wrong_d   = 1'b1;
                        timeout_d = 1'b1;
                    end else begin
                        timer_d = timer_q - CW'(1);
                    end
                end
                RESULT: begin
                    if (timer_q == '0) begin
                        correct_d = 1'b0;
                        wrong_d   = 1'b0;
                        timeout_d = 1'b0;
                        round_d   = round_inc;
                        if (round_inc == ROUNDS_SW) begin
                            state_d  = DONE;
                            target_d = '0;
                        end else begin
                            state_d = GEN;
                        end
                    end else begin
                        timer_d = timer_q - CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            target_q  <= '0;
            score_q   <= '0;
            round_q   <= '0;
            timer_q   <= '0;
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
            timeout_q <= 1'b0;
            start_q   <= 1'b0;
            submit_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            score_q   <= score_d;
            round_q   <= round_d;
            timer_q   <= timer_d;
            correct_q <= correct_d;
            wrong_q   <= wrong_d;
            timeout_q <= timeout_d;
            start_q   <= start_d;
            submit_q  <= submit_d;
        end
    end

    assign target  = target_q;
    assign score   = score_q;
    assign round   = round_q;
    assign active  = (state_q == GEN) || (state_q == WAIT) || (state_q == RESULT);
    assign correct = correct_q;
    assign wrong   = wrong_q;
    assign timeout = timeout_q;
    assign done    = (state_q == DONE);

endmodule
